// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave cook-time controller: FSM states,
// the packed BCD M:SS time record and its digit limits.
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_RUNNING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0] min;
    logic [3:0] dseg;
    logic [3:0] seg;
  } bcd_time_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

  localparam bcd_time_t SAT_TIME = '{min: 4'd9, dseg: 4'd5, seg: 4'd9};
  localparam bcd_time_t ZERO_TIME = '{min: 4'd0, dseg: 4'd0, seg: 4'd0};

  function automatic logic is_zero_time(input bcd_time_t t);
    return t == ZERO_TIME;
  endfunction

endpackage

// File: rtl/bcd_time_dec.sv
// Combinational BCD M:SS arithmetic: one-second decrement with zero detect,
// plus the normalise/saturate step applied to a freshly keyed time.
module bcd_time_dec
  import microwave_pkg::*;
(
  input  bcd_time_t cur,
  output bcd_time_t dec,
  output logic      dec_zero,
  output bcd_time_t norm
);

  // Borrow ripples seg -> dseg -> min; 0:00 never reaches here while running,
  // so the underflow case simply pins to zero.
  always_comb begin
    dec = cur;
    if (cur.seg != 4'd0) begin
      dec.seg = cur.seg - 4'd1;
    end else begin
      dec.seg = BCD_MAX_DIGIT;
      if (cur.dseg != 4'd0) begin
        dec.dseg = cur.dseg - 4'd1;
      end else begin
        dec.dseg = BCD_MAX_TENS;
        if (cur.min != 4'd0) begin
          dec.min = cur.min - 4'd1;
        end else begin
          dec = ZERO_TIME;
        end
      end
    end
  end

  assign dec_zero = is_zero_time(dec);

  // Keyed tens-of-seconds above 5 roll into the minutes; 9:6x and up clamp to 9:59.
  always_comb begin
    norm = cur;
    if (cur.dseg > BCD_MAX_TENS) begin
      if (cur.min >= BCD_MAX_DIGIT) begin
        norm = SAT_TIME;
      end else begin
        norm.min  = cur.min + 4'd1;
        norm.dseg = cur.dseg - 4'd6;
      end
    end
  end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-time controller: keypad entry of M:SS, per-second countdown,
// pause/resume on door or stop, and magnetron enable / done pulse.
module microwave_timer_ctrl
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop_clear,
  input  logic       door_closed,
  output logic [3:0] min_bcd,
  output logic [3:0] dseg_bcd,
  output logic [3:0] seg_bcd,
  output logic       mag_on,
  output logic       done
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  state_t    state, state_n;
  bcd_time_t cur_time, time_n, dec_time, norm_time, shifted_time;
  logic      dec_zero;
  logic [PW-1:0] presc, presc_n;
  logic      tick, key_ok, can_start;

  bcd_time_dec u_dec (
    .cur      (cur_time),
    .dec      (dec_time),
    .dec_zero (dec_zero),
    .norm     (norm_time)
  );

  assign tick      = (presc == PRESC_LAST);
  assign key_ok    = key_valid && (key_digit <= BCD_MAX_DIGIT);
  assign can_start = start && door_closed && !is_zero_time(cur_time);

  assign shifted_time = '{min: cur_time.dseg, dseg: cur_time.seg, seg: key_digit};

  always_comb begin
    state_n = state;
    time_n  = cur_time;
    presc_n = presc;
    case (state)
      ST_IDLE: begin
        if (!stop_clear && key_ok) begin
          time_n  = shifted_time;
          state_n = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (stop_clear) begin
          time_n  = ZERO_TIME;
          state_n = ST_IDLE;
        end else if (can_start) begin
          time_n  = norm_time;
          presc_n = '0;
          state_n = ST_RUNNING;
        end else if (key_ok) begin
          time_n = shifted_time;
        end
      end
      ST_RUNNING: begin
        // Pausing discards a coincident tick: the prescaler wraps but no decrement.
        if (stop_clear || !door_closed) begin
          presc_n = tick ? '0 : presc;
          state_n = ST_PAUSED;
        end else if (tick) begin
          presc_n = '0;
          time_n  = dec_time;
          if (dec_zero) begin
            state_n = ST_DONE;
          end
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      ST_PAUSED: begin
        if (stop_clear) begin
          time_n  = ZERO_TIME;
          presc_n = '0;
          state_n = ST_IDLE;
        end else if (door_closed && start) begin
          state_n = ST_RUNNING;
        end
      end
      ST_DONE: begin
        if (stop_clear) begin
          time_n  = ZERO_TIME;
          state_n = ST_IDLE;
        end else if (key_ok) begin
          time_n  = '{min: 4'd0, dseg: 4'd0, seg: key_digit};
          state_n = ST_ENTRY;
        end
      end
      default: begin
        time_n  = ZERO_TIME;
        presc_n = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cur_time <= ZERO_TIME;
      presc    <= '0;
      mag_on   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cur_time <= time_n;
      presc    <= presc_n;
      mag_on   <= (state_n == ST_RUNNING);
      done     <= (state_n == ST_DONE) && (state != ST_DONE);
    end
  end

  assign min_bcd  = cur_time.min;
  assign dseg_bcd = cur_time.dseg;
  assign seg_bcd  = cur_time.seg;

endmodule
